// File: rtl/ecc_apb_pkg.sv
// ecc_apb_pkg: bridge FSM encodings and ECC register bank offsets shared with the bank
package ecc_apb_pkg;
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_SETUP  = 2'd1;
   localparam state_t ST_ACCESS = 2'd2;
   localparam logic [1:0] CTRL           = 2'd0;
   localparam logic [1:0] DATA_IN        = 2'd1;
   localparam logic [1:0] CODEWORD_WIDTH = 2'd2;
   localparam logic [1:0] NOISE          = 2'd3;
endpackage

// File: rtl/apb_timeout_counter.sv
// apb_timeout_counter: counts stalled ACCESS cycles and flags the edge on which the limit is reached
module apb_timeout_counter #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int W = $clog2(LIMIT + 1);
   logic [W-1:0] cnt;
   // clear on entry to ACCESS, then count every cycle the slave holds PREADY low
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en) cnt <= cnt + 1'b1;
   assign expired = en && cnt == W'(LIMIT - 1);
endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready host command to APB SETUP/ACCESS transfer; APB_TIMEOUT_EN adds an ACCESS watchdog
module apb_master_bridge
   import ecc_apb_pkg::*;
#(
   parameter int AMBA_WORD       = 32,
   parameter int AMBA_ADDR_WIDTH = 2,
   parameter int TIMEOUT_CYCLES  = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic                       cmd_write,
   input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [AMBA_WORD-1:0]       cmd_wdata,
   output logic                       rsp_valid,
   output logic [AMBA_WORD-1:0]       rsp_rdata,
   output logic                       rsp_err,
   output logic                       PSEL,
   output logic                       PENABLE,
   output logic                       PWRITE,
   output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
   output logic [AMBA_WORD-1:0]       PWDATA,
   input  logic [AMBA_WORD-1:0]       PRDATA,
   input  logic                       PREADY,
   input  logic                       PSLVERR
);
   state_t state;
   logic   to_exp;
   assign cmd_ready = state == ST_IDLE;
`ifdef APB_TIMEOUT_EN
   apb_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clr     (state == ST_SETUP),
      .en      (state == ST_ACCESS && !PREADY),
      .expired (to_exp)
   );
`else
   assign to_exp = 1'b0;
`endif
   // transfer sequencer; every APB and response output is a register
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state     <= ST_IDLE;
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            ST_IDLE:
               if (cmd_valid) begin
                  PADDR  <= cmd_addr;
                  PWRITE <= cmd_write;
                  if (cmd_write) PWDATA <= cmd_wdata;
                  PSEL   <= 1'b1;
                  state  <= ST_SETUP;
               end
            ST_SETUP: begin
               PENABLE <= 1'b1;
               state   <= ST_ACCESS;
            end
            ST_ACCESS:
               if (PREADY) begin
                  PSEL      <= 1'b0;
                  PENABLE   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= PSLVERR;
                  if (!PWRITE) rsp_rdata <= PRDATA;
                  state     <= ST_IDLE;
               end else if (to_exp) begin
                  PSEL      <= 1'b0;
                  PENABLE   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
                  state     <= ST_IDLE;
               end
            default: state <= ST_IDLE;
         endcase
      end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed checks of the bridge against a simple APB register bank
module tb_apb_master_bridge;
   import ecc_apb_pkg::*;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cmd_valid = 1'b0, cmd_write = 1'b0;
   logic [1:0]  cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic        cmd_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic        PSEL, PENABLE, PWRITE;
   logic [1:0]  PADDR;
   logic [31:0] PWDATA, PRDATA;
   logic        PREADY = 1'b1, PSLVERR = 1'b0;
   logic [31:0] bank [4] = '{default: '0};
   int          total = 0, bad = 0;

   apb_master_bridge dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   always #5 clk = ~clk;
   assign PRDATA = bank[PADDR];
   always @(posedge clk)
      if (PSEL && PENABLE && PREADY && PWRITE) bank[PADDR] <= PWDATA;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic xfer(input logic w, input logic [1:0] a, input logic [31:0] d,
                       input int waits, input logic err, input logic [31:0] exp_rd);
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; PREADY = 1'b0;
      cyc();
      cmd_valid = 1'b0;
      chk("setup_psel", PSEL, 1);
      chk("setup_penable", PENABLE, 0);
      chk("setup_paddr", PADDR, a);
      chk("setup_pwrite", PWRITE, w);
      chk("busy_ready", cmd_ready, 0);
      if (w) chk("setup_pwdata", PWDATA, d);
      cyc();
      chk("access_penable", PENABLE, 1);
      for (int i = 0; i < waits; i++) begin
         cyc();
         chk("wait_psel", PSEL, 1);
         chk("wait_penable", PENABLE, 1);
         chk("wait_paddr", PADDR, a);
         chk("wait_rsp", rsp_valid, 0);
      end
      PREADY = 1'b1; PSLVERR = err;
      cyc();
      PSLVERR = 1'b0;
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_err", rsp_err, err);
      chk("rsp_rdata", rsp_rdata, exp_rd);
      chk("done_psel", PSEL, 0);
      chk("done_ready", cmd_ready, 1);
      cyc();
      chk("rsp_pulse", rsp_valid, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_psel", PSEL, 0);
      chk("rst_rsp", rsp_valid, 0);
      chk("rst_pwdata", PWDATA, 0);
      rst = 1'b1;
      cyc();
      // 1: write CTRL, zero waits
      xfer(1'b1, CTRL, 32'h0000_0005, 0, 1'b0, 32'h0);
      chk("bank_ctrl", bank[0], 32'h5);
      // 2: write then read NOISE
      xfer(1'b1, NOISE, 32'hA5A5_0001, 0, 1'b0, 32'h0);
      xfer(1'b0, NOISE, 32'h0, 0, 1'b0, 32'hA5A5_0001);
      chk("read_keeps_pwdata", PWDATA, 32'hA5A5_0001);
      // 3: read CTRL with 4 wait states and slave error
      xfer(1'b0, CTRL, 32'h0, 4, 1'b1, 32'h5);
      // 4: back-to-back writes with cmd_valid held
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = DATA_IN; cmd_wdata = 32'd11; PREADY = 1'b1;
      cyc(); cyc(); cyc();
      chk("b2b_rsp1", rsp_valid, 1);
      chk("b2b_gap_psel", PSEL, 0);
      chk("b2b_ready", cmd_ready, 1);
      cmd_addr = CODEWORD_WIDTH; cmd_wdata = 32'd22;
      cyc();
      cmd_valid = 1'b0;
      chk("b2b_psel2", PSEL, 1);
      chk("b2b_paddr2", PADDR, CODEWORD_WIDTH);
      chk("b2b_rsp_low", rsp_valid, 0);
      cyc(); cyc();
      chk("b2b_rsp2", rsp_valid, 1);
      chk("b2b_bank1", bank[1], 32'd11);
      chk("b2b_bank2", bank[2], 32'd22);
      cyc();
`ifdef APB_TIMEOUT_EN
      // 5: stuck slave aborts after 16 ACCESS cycles
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = CTRL; PREADY = 1'b0;
      cyc();
      cmd_valid = 1'b0;
      cyc();
      for (int i = 1; i <= 16; i++) begin
         cyc();
         if (i < 16) chk("to_pending", rsp_valid, 0);
      end
      chk("to_rsp", rsp_valid, 1);
      chk("to_err", rsp_err, 1);
      chk("to_rdata", rsp_rdata, 0);
      chk("to_ready", cmd_ready, 1);
      chk("to_psel", PSEL, 0);
      PREADY = 1'b1;
      cyc();
`endif
      // 6: reset during ACCESS aborts the write
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = CODEWORD_WIDTH; cmd_wdata = 32'd77; PREADY = 1'b0;
      cyc();
      cmd_valid = 1'b0;
      cyc();
      rst = 1'b0;
      #1;
      chk("mid_rst_psel", PSEL, 0);
      chk("mid_rst_penable", PENABLE, 0);
      chk("mid_rst_paddr", PADDR, 0);
      chk("mid_rst_pwdata", PWDATA, 0);
      chk("mid_rst_rdata", rsp_rdata, 0);
      chk("mid_rst_ready", cmd_ready, 1);
      PREADY = 1'b1;
      cyc();
      chk("mid_rst_norsp", rsp_valid, 0);
      rst = 1'b1;
      cyc();
      chk("mid_rst_bank", bank[2], 32'd22);
      xfer(1'b0, CODEWORD_WIDTH, 32'h0, 0, 1'b0, 32'd22);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
